// File: rtl/cpu_multicycle_control.sv
// cpu_multicycle_control
// Moore main-control FSM for a multicycle MIPS datapath with a shared ALU and a
// single memory. It handles R-type, lw, sw, beq, j and addi. Funct decoding is
// left to a separate ALU-control block, which is driven through ALUOp.
// Optional build macro OVF_EXCEPTION_EN: a signed overflow in EXEC or ADDIEX
// traps to the OVF state, which loads EPC and Cause and vectors the PC.
// Without the macro, Overflow is ignored and EPCWrite/CauseWrite stay 0.
module cpu_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_OVF    = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_supported;

  // Opcode belongs to the supported subset; anything else decodes as a NOP.
  assign w_supported = (Opcode == OP_RTYPE) || (Opcode == OP_LW)  ||
                       (Opcode == OP_SW)    || (Opcode == OP_BEQ) ||
                       (Opcode == OP_J)     || (Opcode == OP_ADDI);

`ifndef OVF_EXCEPTION_EN
  // Overflow has no effect in this build; the tie-off documents that on purpose.
  logic w_unused_ovf;
  assign w_unused_ovf = Overflow;
`endif

  // State register: reset drops the FSM back to FETCH, abandoning any instruction.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Next-state logic: fixed successor except in DECODE, MEMADR and (optionally) the ALU states.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if ((Opcode == OP_LW) || (Opcode == OP_SW)) w_next = S_MEMADR;
        else if (Opcode == OP_RTYPE)                w_next = S_EXEC;
        else if (Opcode == OP_BEQ)                  w_next = S_BEQ;
        else if (Opcode == OP_J)                    w_next = S_JUMP;
        else if (Opcode == OP_ADDI)                 w_next = S_ADDIEX;
        else                                        w_next = S_FETCH;
      end
      S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
`ifdef OVF_EXCEPTION_EN
      S_EXEC:   w_next = Overflow ? S_OVF : S_RWB;
      S_ADDIEX: w_next = Overflow ? S_OVF : S_ADDIWB;
`else
      S_EXEC:   w_next = S_RWB;
      S_ADDIEX: w_next = S_ADDIWB;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the state; everything is forced to 0 while reset is held.
  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    EPCWrite    = 1'b0;
    CauseWrite  = 1'b0;
    IllegalOp   = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
        end
        S_DECODE: begin
          ALUSrcB   = 2'b11;
          IllegalOp = ~w_supported;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b10;
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          RegWrite = 1'b1;
        end
`ifdef OVF_EXCEPTION_EN
        S_OVF: begin
          EPCWrite   = 1'b1;
          CauseWrite = 1'b1;
          PCWrite    = 1'b1;
          PCSource   = 2'b11;
        end
`endif
        default: ;
      endcase
    end
  end

  assign State = r_state;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// tb_cpu_multicycle_control
// Self-checking bench: a table of {opcode, overflow, expected outputs} rows walks
// every instruction class cycle by cycle; expected records go through a scoreboard
// queue. Hand-written sequences cover reset hold/release and mid-instruction reset.
// Expectations for the overflow rows follow OVF_EXCEPTION_EN.
module tb_cpu_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       epc_write;
    logic       cause_write;
    logic       illegal_op;
    logic [3:0] state;
  } ctrl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       ovf;
    ctrl_t      exp;
  } vec_t;

  // Expected output records per state, written from the control table by hand.
  localparam ctrl_t C_RESET   = '{default: '0};
  localparam ctrl_t C_FETCH   = '{pc_write: 1'b1, mem_read: 1'b1, ir_write: 1'b1,
                                  alu_src_b: 2'b01, state: 4'd0, default: '0};
  localparam ctrl_t C_DECODE  = '{alu_src_b: 2'b11, state: 4'd1, default: '0};
  localparam ctrl_t C_DEC_ILL = '{alu_src_b: 2'b11, illegal_op: 1'b1, state: 4'd1, default: '0};
  localparam ctrl_t C_MEMADR  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, state: 4'd2, default: '0};
  localparam ctrl_t C_MEMRD   = '{mem_read: 1'b1, iord: 1'b1, state: 4'd3, default: '0};
  localparam ctrl_t C_MEMWB   = '{reg_write: 1'b1, mem_to_reg: 1'b1, state: 4'd4, default: '0};
  localparam ctrl_t C_MEMWR   = '{mem_write: 1'b1, iord: 1'b1, state: 4'd5, default: '0};
  localparam ctrl_t C_EXEC    = '{alu_src_a: 1'b1, alu_op: 2'b10, state: 4'd6, default: '0};
  localparam ctrl_t C_RWB     = '{alu_src_a: 1'b1, alu_op: 2'b10, reg_write: 1'b1,
                                  reg_dst: 1'b1, state: 4'd7, default: '0};
  localparam ctrl_t C_BEQ     = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1,
                                  pc_source: 2'b01, state: 4'd8, default: '0};
  localparam ctrl_t C_JUMP    = '{pc_write: 1'b1, pc_source: 2'b10, state: 4'd9, default: '0};
  localparam ctrl_t C_ADDIEX  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, state: 4'd10, default: '0};
  localparam ctrl_t C_ADDIWB  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, reg_write: 1'b1,
                                  state: 4'd11, default: '0};
  localparam ctrl_t C_OVF     = '{epc_write: 1'b1, cause_write: 1'b1, pc_write: 1'b1,
                                  pc_source: 2'b11, state: 4'd12, default: '0};

  logic       clk;
  logic       rst;
  logic [5:0] Opcode;
  logic       Overflow;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, EPCWrite, CauseWrite, IllegalOp;
  logic [3:0] State;

  int    n_checks;
  int    n_failures;
  vec_t  vecs[$];
  ctrl_t sb_q[$];

  cpu_multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .Opcode     (Opcode),
    .Overflow   (Overflow),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .EPCWrite   (EPCWrite),
    .CauseWrite (CauseWrite),
    .IllegalOp  (IllegalOp),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t sample();
    ctrl_t s;
    s = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
         PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
         EPCWrite, CauseWrite, IllegalOp, State};
    return s;
  endfunction

  task automatic check(input string name, input ctrl_t act, input ctrl_t exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got=%06h (state %0d) expected=%06h (state %0d)",
               name, act, act.state, exp, exp.state);
    end
  endtask

  task automatic pop_check(input string name);
    ctrl_t exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb_q.pop_front();
      check(name, sample(), exp);
    end
  endtask

  task automatic add(input string name, input logic [5:0] op, input logic ovf, input ctrl_t exp);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.ovf  = ovf;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs at the negedge, check #1 later, then advance a cycle.
  task automatic apply(input vec_t v);
    Opcode   = v.op;
    Overflow = v.ovf;
    sb_q.push_back(v.exp);
    #1;
    pop_check(v.name);
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_failures = 0;
    rst        = 1'b0;
    Opcode     = 6'b0;
    Overflow   = 1'b0;

    // lw: 5 cycles
    add("lw_fetch", OP_LW, 1'b0, C_FETCH);   add("lw_decode", OP_LW, 1'b0, C_DECODE);
    add("lw_memadr", OP_LW, 1'b0, C_MEMADR); add("lw_memrd", OP_LW, 1'b0, C_MEMRD);
    add("lw_memwb", OP_LW, 1'b0, C_MEMWB);
    // sw: 4 cycles
    add("sw_fetch", OP_SW, 1'b0, C_FETCH);   add("sw_decode", OP_SW, 1'b0, C_DECODE);
    add("sw_memadr", OP_SW, 1'b0, C_MEMADR); add("sw_memwr", OP_SW, 1'b0, C_MEMWR);
    // beq: 3 cycles
    add("beq_fetch", OP_BEQ, 1'b0, C_FETCH); add("beq_decode", OP_BEQ, 1'b0, C_DECODE);
    add("beq_exec", OP_BEQ, 1'b0, C_BEQ);
    // R-type: 4 cycles
    add("r_fetch", OP_RTYPE, 1'b0, C_FETCH); add("r_decode", OP_RTYPE, 1'b0, C_DECODE);
    add("r_exec", OP_RTYPE, 1'b0, C_EXEC);   add("r_wb", OP_RTYPE, 1'b0, C_RWB);
    // j: 3 cycles
    add("j_fetch", OP_J, 1'b0, C_FETCH);     add("j_decode", OP_J, 1'b0, C_DECODE);
    add("j_jump", OP_J, 1'b0, C_JUMP);
    // unknown opcodes: one IllegalOp cycle in DECODE, then straight back to FETCH
    add("ill3f_fetch", 6'h3f, 1'b0, C_FETCH); add("ill3f_decode", 6'h3f, 1'b0, C_DEC_ILL);
    add("ill03_fetch", 6'h03, 1'b0, C_FETCH); add("ill03_decode", 6'h03, 1'b0, C_DEC_ILL);
    // addi without overflow: 4 cycles
    add("addi_fetch", OP_ADDI, 1'b0, C_FETCH); add("addi_decode", OP_ADDI, 1'b0, C_DECODE);
    add("addi_ex", OP_ADDI, 1'b0, C_ADDIEX);   add("addi_wb", OP_ADDI, 1'b0, C_ADDIWB);
    // addi and R-type with Overflow high at the end of the execute cycle
    add("addiov_fetch", OP_ADDI, 1'b0, C_FETCH); add("addiov_decode", OP_ADDI, 1'b0, C_DECODE);
    add("addiov_ex", OP_ADDI, 1'b1, C_ADDIEX);
`ifdef OVF_EXCEPTION_EN
    add("addiov_trap", OP_ADDI, 1'b0, C_OVF);
`else
    add("addiov_wb", OP_ADDI, 1'b0, C_ADDIWB);
`endif
    add("rov_fetch", OP_RTYPE, 1'b0, C_FETCH); add("rov_decode", OP_RTYPE, 1'b0, C_DECODE);
    add("rov_exec", OP_RTYPE, 1'b1, C_EXEC);
`ifdef OVF_EXCEPTION_EN
    add("rov_trap", OP_RTYPE, 1'b0, C_OVF);
`else
    add("rov_wb", OP_RTYPE, 1'b0, C_RWB);
`endif
    // Overflow outside the execute states must not matter
    add("ovfidle_fetch", OP_LW, 1'b1, C_FETCH); add("ovfidle_decode", OP_LW, 1'b1, C_DECODE);
    add("ovfidle_memadr", OP_LW, 1'b1, C_MEMADR); add("ovfidle_memrd", OP_LW, 1'b1, C_MEMRD);
    add("ovfidle_memwb", OP_LW, 1'b1, C_MEMWB);
    add("end_fetch", OP_J, 1'b0, C_FETCH);       add("end_decode", OP_J, 1'b0, C_DECODE);
    add("end_jump", OP_J, 1'b0, C_JUMP);

    // Reset held for three cycles: FETCH state, every enable and select 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sb_q.push_back(C_RESET);
      #1;
      pop_check("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Mid-instruction reset: sw abandoned in MEMADR must never reach MemWrite.
    Opcode = OP_SW;
    Overflow = 1'b0;
    @(negedge clk);          // DECODE
    @(negedge clk);          // MEMADR
    sb_q.push_back(C_MEMADR);
    #1;
    pop_check("midrst_memadr");
    rst = 1'b0;
    sb_q.push_back(C_RESET);
    #1;
    pop_check("midrst_async");
    @(posedge clk);
    sb_q.push_back(C_RESET);
    #1;
    pop_check("midrst_held");
    @(negedge clk);
    rst = 1'b1;
    sb_q.push_back(C_FETCH);
    #1;
    pop_check("midrst_release_fetch");
    @(negedge clk);
    sb_q.push_back(C_DECODE);
    #1;
    pop_check("midrst_decode");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
